// File: rtl/pio_in_pkg.sv
// Shared constants for the parametrised input PIO with interrupt.
package pio_in_pkg;

    // Register word addresses on the Avalon-MM slave
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Which input transitions set edgecapture
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Source of the interrupt request
    localparam int IRQ_EDGE  = 0;
    localparam int IRQ_LEVEL = 1;

    // Power-up arming sequence: hold off edge detection until the
    // synchroniser has flushed the power-up input levels
    typedef enum logic {
        ARMING = 1'b0,
        ARMED  = 1'b1
    } arm_state_t;

endpackage

// File: rtl/pio_in_debounce.sv
// Single-bit debounce filter: a change on the synchronised input is only
// accepted after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
// While the block is still arming, the output simply follows the input.
module pio_in_debounce
    import pio_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic armed,
    input  logic sync_in,
    output logic deb_out
);

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering requested: pass straight through with no latency
            logic unused_bypass;
            assign unused_bypass = &{1'b0, clk, reset, armed};
            assign deb_out       = sync_in;
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_ACCEPT = CW'(DEBOUNCE_CYCLES);

            logic [CW-1:0] count;
            logic [CW-1:0] count_next;
            logic          stable;

            assign count_next = count + CW'(1);

            // Count consecutive disagreeing samples; accept the new level when the run is long enough
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count  <= '0;
                    stable <= 1'b0;
                end else if (!armed) begin
                    count  <= '0;
                    stable <= sync_in;
                end else if (sync_in == stable) begin
                    count  <= '0;
                end else if (count_next == CNT_ACCEPT) begin
                    count  <= '0;
                    stable <= sync_in;
                end else begin
                    count  <= count_next;
                end
            end

            assign deb_out = stable;
        end
    endgenerate

endmodule

// File: rtl/pio_in_irq.sv
// Parametrised Avalon-MM input PIO: synchroniser, optional per-bit debounce,
// edge capture with write-1-to-clear, interrupt mask and a registered irq.
module pio_in_irq
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // The arming counter must be able to hold SYNC_STAGES
    localparam int                ARM_CW   = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_CW-1:0] ARM_LAST = ARM_CW'(SYNC_STAGES);

    logic [WIDTH-1:0]  sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0]  sync_bits;
    logic [WIDTH-1:0]  deb;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic [WIDTH-1:0]  edge_hits;
    logic [WIDTH-1:0]  clear_bits;
    logic [WIDTH-1:0]  edgecapture;
    logic [WIDTH-1:0]  irqmask;
    logic [WIDTH-1:0]  wr_bits;
    logic [31:0]       rd_next;
    logic              bus_write;
    logic              armed;
    logic [ARM_CW-1:0] arm_cnt;
    arm_state_t        arm_state;
    arm_state_t        arm_state_next;
    logic              unused_wdata;

    assign bus_write    = chipselect & ~write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign unused_wdata = &{1'b0, writedata};

    // Bring the asynchronous inputs into the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= '0;
            end
        end else begin
            sync_chain[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= sync_chain[s-1];
            end
        end
    end

    assign sync_bits = sync_chain[SYNC_STAGES-1];

    // Count arming cycles until the synchroniser holds real input levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt <= '0;
        end else if (arm_state == ARMING && arm_cnt != ARM_LAST) begin
            arm_cnt <= arm_cnt + ARM_CW'(1);
        end
    end

    // Arming FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_state <= ARMING;
        end else begin
            arm_state <= arm_state_next;
        end
    end

    // Arming FSM next state: leave ARMING once the counter expires, then stay ARMED
    always_comb begin
        arm_state_next = arm_state;
        case (arm_state)
            ARMING:  if (arm_cnt == ARM_LAST) arm_state_next = ARMED;
            ARMED:   arm_state_next = ARMED;
            default: arm_state_next = ARMING;
        endcase
    end

    // Arming FSM outputs
    always_comb begin
        armed = 1'b0;
        case (arm_state)
            ARMED:   armed = 1'b1;
            default: armed = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_deb
            pio_in_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset   (reset),
                .armed   (armed),
                .sync_in (sync_bits[gi]),
                .deb_out (deb[gi])
            );
        end
    endgenerate

    // Remember the last accepted value; while arming, track the level deb is about to take
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else if (armed) begin
            prev <= deb;
        end else begin
            prev <= sync_bits;
        end
    end

    assign rise = deb & ~prev;
    assign fall = ~deb & prev;

    // Pick the transitions that count as an edge; nothing counts before arming completes
    always_comb begin
        edge_hits = '0;
        if (armed) begin
            case (EDGE_TYPE)
                EDGE_RISING:  edge_hits = rise;
                EDGE_FALLING: edge_hits = fall;
                default:      edge_hits = rise | fall;
            endcase
        end
    end

    assign clear_bits = (bus_write && address == ADDR_EDGECAP) ? wr_bits : '0;

    // Sticky edge capture; a new edge overrides a simultaneous clear of the same bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~clear_bits) | edge_hits;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask <= '0;
        end else if (bus_write && address == ADDR_IRQMASK) begin
            irqmask <= wr_bits;
        end
    end

    // Register the interrupt one cycle after its source
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (IRQ_MODE == IRQ_LEVEL) begin
            irq <= |(deb & irqmask);
        end else begin
            irq <= |(edgecapture & irqmask);
        end
    end

    // Read mux; reads do not need chipselect and unused upper bits stay zero
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = deb;
            ADDR_RSVD:    rd_next = '0;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
            default:      rd_next = '0;
        endcase
    end

    // Registered read data gives a fixed one-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_pio_in_irq.sv
// Testbench for pio_in_irq: two instances (plain rising-edge/edge-irq and
// debounced any-edge/level-irq) sharing one bus, checked cycle by cycle
// against a history-based reference model plus directed scenarios.
module tb_pio_in_irq;
    import pio_in_pkg::*;

    localparam int W    = 10;
    localparam int SYNC = 2;
    localparam int DEB1 = 4;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = 32'd0;
    logic [W-1:0]  in0        = '0;
    logic [W-1:0]  in1        = '0;
    logic [31:0]   rd0, rd1;
    logic          irq0, irq1;

    int assertCount = 0;
    int failCount   = 0;
    bit checkEn     = 1'b0;

    always #5 clk = ~clk;

    pio_in_irq #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0),
        .EDGE_TYPE(EDGE_RISING), .IRQ_MODE(IRQ_EDGE)
    ) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .irq(irq0)
    );

    pio_in_irq #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB1),
        .EDGE_TYPE(EDGE_ANY), .IRQ_MODE(IRQ_LEVEL)
    ) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .irq(irq1)
    );

    // ---------------- reference model ----------------
    // Model m describes dut<m>; history arrays hold one sample per clock, [0] newest.
    logic [W-1:0] inHist   [2][8];
    logic [W-1:0] syncHist [2][8];
    logic [W-1:0] mSync [2];
    logic [W-1:0] mDeb  [2];
    logic [W-1:0] mPrev [2];
    logic [W-1:0] mEc   [2];
    logic [W-1:0] mMask [2];
    logic [31:0]  mRd   [2];
    logic         mIrq  [2];
    int           mCyc  [2];

    function automatic int debOf(input int m);
        return (m == 0) ? 0 : DEB1;
    endfunction

    function automatic int edgeOf(input int m);
        return (m == 0) ? EDGE_RISING : EDGE_ANY;
    endfunction

    function automatic int irqOf(input int m);
        return (m == 0) ? IRQ_EDGE : IRQ_LEVEL;
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int j = 0; j < 8; j++) begin
                inHist[m][j]   = '0;
                syncHist[m][j] = '0;
            end
            mSync[m] = '0; mDeb[m] = '0; mPrev[m] = '0;
            mEc[m]   = '0; mMask[m] = '0; mRd[m] = '0;
            mIrq[m]  = 1'b0; mCyc[m] = 0;
        end
    endtask

    // Advance model m by one clock, using the values visible just before the edge
    task automatic modelStep(input int m, input logic [W-1:0] inVal);
        int           d;
        logic [W-1:0] sB, dB, pB, eB, kB, hits, clr;
        bit           armedB, wr, run;
        d      = debOf(m);
        sB     = mSync[m];
        dB     = (d == 0) ? sB : mDeb[m];
        pB     = mPrev[m];
        eB     = mEc[m];
        kB     = mMask[m];
        armedB = (mCyc[m] >= SYNC + 1);
        wr     = chipselect && !write_n;

        hits = '0;
        if (armedB) begin
            if (edgeOf(m) == EDGE_RISING)       hits = dB & ~pB;
            else if (edgeOf(m) == EDGE_FALLING) hits = ~dB & pB;
            else                                hits = dB ^ pB;
        end
        clr      = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        mEc[m]   = (eB & ~clr) | hits;
        mMask[m] = (wr && address == 2'd2) ? writedata[W-1:0] : kB;
        mIrq[m]  = (irqOf(m) == IRQ_LEVEL) ? |(dB & kB) : |(eB & kB);
        case (address)
            2'd0:    mRd[m] = 32'(dB);
            2'd2:    mRd[m] = 32'(kB);
            2'd3:    mRd[m] = 32'(eB);
            default: mRd[m] = 32'd0;
        endcase
        mPrev[m] = armedB ? dB : sB;

        for (int j = 7; j > 0; j--) syncHist[m][j] = syncHist[m][j-1];
        syncHist[m][0] = sB;
        if (d > 0) begin
            if (!armedB) begin
                mDeb[m] = sB;
            end else begin
                for (int b = 0; b < W; b++) begin
                    run = 1'b1;
                    for (int j = 0; j < d; j++) begin
                        if (syncHist[m][j][b] == dB[b]) run = 1'b0;
                    end
                    if (run) mDeb[m][b] = ~dB[b];
                end
            end
        end

        for (int j = 7; j > 0; j--) inHist[m][j] = inHist[m][j-1];
        inHist[m][0] = inVal;
        mSync[m]     = inHist[m][SYNC-1];
        mCyc[m]      = mCyc[m] + 1;
    endtask

    // ---------------- checking ----------------
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Step the model on every edge and compare both DUTs shortly after it
    always @(posedge clk) begin
        if (reset) begin
            modelReset();
        end else begin
            modelStep(0, in0);
            modelStep(1, in1);
        end
        #2;
        if (checkEn && !reset) begin
            checkOutput("model rd0",  rd0, mRd[0]);
            checkOutput("model irq0", {31'd0, irq0}, {31'd0, mIrq[0]});
            checkOutput("model rd1",  rd1, mRd[1]);
            checkOutput("model irq1", {31'd0, irq1}, {31'd0, mIrq[1]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input logic [1:0] addr, input logic cs, input logic wn, input logic [31:0] wd);
        @(negedge clk);
        address    = addr;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] wd);
        applyStimulus(addr, 1'b1, 1'b0, wd);
        applyStimulus(addr, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic busRead(input logic [1:0] addr);
        applyStimulus(addr, 1'b0, 1'b1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-up with all inputs high: no false edges may appear
        in0 = 10'h3FF;
        in1 = 10'h3FF;
        repeat (4) @(negedge clk);
        checkOutput("reset readdata0", rd0, 32'd0);
        checkOutput("reset irq0", {31'd0, irq0}, 32'd0);
        reset   = 1'b0;
        checkEn = 1'b1;
        repeat (10) @(negedge clk);
        busRead(2'd0);
        checkOutput("powerup data0", rd0, 32'h3FF);
        checkOutput("powerup data1", rd1, 32'h3FF);
        busRead(2'd3);
        checkOutput("powerup edgecap0", rd0, 32'd0);
        checkOutput("powerup edgecap1", rd1, 32'd0);
        checkOutput("powerup irq0", {31'd0, irq0}, 32'd0);

        // Drop inputs, let the debounced part settle, clear captures, set masks
        @(negedge clk);
        in0 = '0;
        in1 = '0;
        repeat (12) @(negedge clk);
        busWrite(2'd3, 32'h3FF);
        busWrite(2'd2, 32'h101);
        busRead(2'd3);
        checkOutput("cleared edgecap0", rd0, 32'd0);
        checkOutput("cleared edgecap1", rd1, 32'd0);

        // Rising edge on bit 0: capture after SYNC+1 edges, irq one edge later
        @(negedge clk);
        in0[0]  = 1'b1;
        address = 2'd3;
        repeat (SYNC + 1) @(negedge clk);
        checkOutput("edge0 early read", rd0, 32'd0);
        checkOutput("edge0 early irq", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        checkOutput("edge0 capture", rd0, 32'h001);
        checkOutput("edge0 irq", {31'd0, irq0}, 32'd1);
        busWrite(2'd3, 32'h001);
        @(negedge clk);
        checkOutput("w1c edgecap0", rd0, 32'd0);
        checkOutput("w1c irq0", {31'd0, irq0}, 32'd0);

        // Edge on bit 3 coincides with a clear of bit 3: the set wins
        @(negedge clk);
        in0[3] = 1'b1;
        @(negedge clk);
        applyStimulus(2'd3, 1'b1, 1'b0, 32'h008);
        applyStimulus(2'd3, 1'b0, 1'b1, 32'd0);
        @(negedge clk);
        checkOutput("set wins", rd0, 32'h008);
        busWrite(2'd3, 32'h3F7);
        busRead(2'd3);
        checkOutput("partial clear", rd0, 32'h008);

        // Debounced instance: a 3-cycle glitch on bit 5 is rejected
        @(negedge clk);
        in1[5] = 1'b1;
        repeat (3) @(negedge clk);
        in1[5] = 1'b0;
        repeat (10) @(negedge clk);
        busRead(2'd0);
        checkOutput("glitch data1", rd1, 32'd0);
        busRead(2'd3);
        checkOutput("glitch edgecap1", rd1, 32'd0);

        // A stable change reaches deb exactly SYNC+DEB1 edges after the input moves
        @(negedge clk);
        in1[5]  = 1'b1;
        address = 2'd0;
        repeat (SYNC + DEB1) @(negedge clk);
        checkOutput("debounce not yet", rd1 & 32'h020, 32'd0);
        @(negedge clk);
        checkOutput("debounce accepted", rd1 & 32'h020, 32'h020);

        // Level irq on bit 8 follows the debounced input; both edges captured
        @(negedge clk);
        in1[8] = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("level irq set", {31'd0, irq1}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("level irq held", {31'd0, irq1}, 32'd1);
        busRead(2'd3);
        checkOutput("rise capture bit8", rd1 & 32'h100, 32'h100);
        busWrite(2'd3, 32'h100);
        @(negedge clk);
        in1[8] = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("level irq clear", {31'd0, irq1}, 32'd0);
        busRead(2'd3);
        checkOutput("fall capture bit8", rd1 & 32'h100, 32'h100);

        // Register map corners
        busWrite(2'd2, 32'hFFFF_FFFF);
        busRead(2'd2);
        checkOutput("irqmask width0", rd0, 32'h3FF);
        checkOutput("irqmask width1", rd1, 32'h3FF);
        checkOutput("edge irq from bit3", {31'd0, irq0}, 32'd1);
        busRead(2'd1);
        checkOutput("reserved read", rd0, 32'd0);
        busWrite(2'd0, 32'h155);
        busRead(2'd0);
        checkOutput("data write ignored", rd0, 32'(in0));
        applyStimulus(2'd2, 1'b0, 1'b0, 32'h0);
        busRead(2'd2);
        checkOutput("write without cs", rd0, 32'h3FF);

        // Randomised traffic on both input ports and the bus
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) in0 = W'($urandom);
            if ($urandom_range(0, 9) == 0) in1 = W'($urandom);
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) != 0);
            writedata  = $urandom;
        end
        applyStimulus(2'd0, 1'b0, 1'b1, 32'd0);

        // Reset in the middle of a debounce run clears everything at once
        busWrite(2'd2, 32'h3FF);
        @(negedge clk);
        in1[2] = ~in1[2];
        repeat (SYNC + 2) @(negedge clk);
        checkOutput("pre-reset read", rd0, 32'h3FF);
        reset = 1'b1;
        #1;
        checkOutput("async reset rd0", rd0, 32'd0);
        checkOutput("async reset rd1", rd1, 32'd0);
        checkOutput("async reset irq0", {31'd0, irq0}, 32'd0);
        checkOutput("async reset irq1", {31'd0, irq1}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        busRead(2'd2);
        checkOutput("mask after reset", rd0, 32'd0);
        busRead(2'd3);
        checkOutput("edgecap after reset0", rd0, 32'd0);
        checkOutput("edgecap after reset1", rd1, 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pio_in_irq.md
Name: pio_in_irq

Overview:
Parametrised successor to the 10-bit switch input PIO. It is an Avalon-MM slave that reads WIDTH external inputs and provides:
- a synchroniser and optional per-bit debounce;
- edge capture;
- an interrupt mask and a registered irq output.
It sits between board switches/keys and the system interconnect; software polls it or takes its interrupt.

Parameters:
WIDTH, 10, number of input bits (1..32).
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (>=2).
DEBOUNCE_CYCLES, 0, consecutive stable cycles before a bit change is accepted; 0 bypasses debounce.
EDGE_TYPE, 0, edge that sets edgecapture: 0 rising, 1 falling, 2 any.
IRQ_MODE, 0, 0 edge (irq from edgecapture), 1 level (irq from data).

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  asynchronous, active-high reset.
address  in  2  register word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe, qualified by chipselect.
writedata  in  32  write data.
readdata  out  32  registered read data.
in_port  in  WIDTH  asynchronous external inputs.
irq  out  1  registered interrupt request, active-high.

Behaviour:
- Reset values: readdata=0, irq=0, irqmask=0, edgecapture=0; sync chain, debounced value, previous value and debounce counters all 0; arming FSM in ARMING.
- Register map. All reads return WIDTH bits zero-extended to 32; upper bits are always 0.
  - Addr 0 data: read-only; returns the debounced value; writes are ignored.
  - Addr 1: reserved; reads 0; writes are ignored.
  - Addr 2 irqmask: R/W; stores writedata[WIDTH-1:0].
  - Addr 3 edgecapture: read; write-1-to-clear per bit.
- Reads: readdata is updated every cycle from address (mux then register), giving 1-cycle latency; chipselect is not required for reads.
- Synchroniser: in_port passes through SYNC_STAGES flip-flops to give sync[i].
- Debounce, per bit, when DEBOUNCE_CYCLES>0:
  - counter width is clog2(DEBOUNCE_CYCLES+1);
  - counter clears whenever sync[i]==deb[i];
  - otherwise it increments; on reaching DEBOUNCE_CYCLES, deb[i]<=sync[i] and the counter clears;
  - a glitch shorter than DEBOUNCE_CYCLES never reaches deb.
- With DEBOUNCE_CYCLES=0: deb = sync, no extra latency.
- Arming FSM: prevents false edges from power-up input levels.
  - ARMING: deb tracks sync directly, with no debounce and no captures. A counter runs for SYNC_STAGES+1 cycles, then the FSM moves to ARMED.
  - ARMED: normal operation. The FSM stays ARMED until reset.
- Edge detection (ARMED only): prev<=deb every cycle.
  - rise = deb & ~prev; fall = ~deb & prev.
  - The edge vector is selected by EDGE_TYPE (2 = rise|fall).
- edgecapture update: edgecapture <= (edgecapture & ~clr) | edge, where clr = writedata[WIDTH-1:0] on a write to addr 3, else 0.
  - If an edge and a clear hit the same bit in the same cycle, the set wins.
- irq is registered, one cycle after its source:
  - IRQ_MODE 0: irq <= |(edgecapture & irqmask);
  - IRQ_MODE 1: irq <= |(deb & irqmask).
- Latency from an in_port change to a data read change: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - edgecapture sets 1 cycle after the deb change; irq follows 1 cycle later.
- A write with write_n=0 and chipselect=0 has no effect.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and the FSM re-enters ARMING.

Decomposition:
- Package pio_in_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY=0/1/2;
  - IRQ_EDGE/IRQ_LEVEL=0/1.
- One sub-module, pio_in_debounce: a single-bit counter and stable register, instantiated WIDTH times by a generate loop. The top level holds the synchroniser, FSM, edge/capture logic and bus registers.

Test Plan:
- Reset with in_port=10'h3FF held, release reset, wait 10 cycles -> data reads 0x3FF, edgecapture reads 0, irq=0 (no false edges).
- WIDTH=10, EDGE_TYPE=0, irqmask=0x001, in_port[0] 0->1 -> edgecapture=0x001 at SYNC_STAGES+1 cycles, irq=1 one cycle later. Write 0x001 to addr 3 -> edgecapture=0, irq=0 one cycle after.
- Edge on bit 3 in the same cycle as a W1C write of 0x008 -> bit 3 remains 1 (set wins). Write 0x3F7 to addr 3 -> bit 3 still set.
- DEBOUNCE_CYCLES=4: 3-cycle pulse on in_port[5] -> data unchanged, no capture. 6-cycle-stable change -> data bit 5 flips exactly SYNC_STAGES+4 cycles after the input change.
- EDGE_TYPE=2, IRQ_MODE=1, irqmask=0x100: in_port[8] 0->1 -> irq asserts and stays while high. 1->0 -> irq clears. edgecapture bit 8 is set by both edges.
- Write 0xFFFFFFFF to addr 2, read addr 2 -> 0x000003FF. Read addr 1 -> 0. Write to addr 0 -> data unchanged. Assert reset mid-debounce -> all outputs 0 immediately.
